axis_out_pkt_buffer: RTL and testbench

Store-and-forward packet buffer directly downstream of the P4 processor wrapper's AXIS master output, feeding the SUME output queues. It absorbs the processor's non-backpressurable output and holds each packet's tuser, captured on its first beat, stable for the whole outbound packet. It releases only complete packets and drops whole packets on overflow. It also exports forward/drop statistics.

---
 rtl/axis_out_pkt_buffer.sv | 240 ++++++++++++++++++++++++
 tb/tb_axis_out_pkt_buffer.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_out_pkt_buffer.sv
// -----------------------------------------------------------------------------
// axis_out_pkt_buffer
//
// Store-and-forward packet buffer placed after the P4 processor wrapper's AXIS
// master output. The input side never applies backpressure. A packet that does
// not fit is dropped whole, and a partially written packet is rolled back. Only
// fully committed packets are released on m_axis. Each packet's tuser is
// sampled on its first beat and held constant for the whole outbound packet.
//
// Ports
//   obuf_aclk / obuf_arst        clock, asynchronous active-high reset
//   s_axis_*                     input stream (tready is 0 in reset, 1 after)
//   m_axis_*                     output stream, complete packets only
//   stat_pkt_fwd                 packets fully transmitted on m_axis (wraps)
//   stat_pkt_drop                packets discarded on overflow (wraps)
//   stat_fill                    data FIFO occupancy in beats
// -----------------------------------------------------------------------------
module axis_out_pkt_buffer #(
  parameter int C_AXIS_DATA_WIDTH  = 256,
  parameter int C_AXIS_TUSER_WIDTH = 128,
  parameter int DATA_DEPTH_LOG2    = 6,
  parameter int META_DEPTH_LOG2    = 3
) (
  input  logic                            obuf_aclk,
  input  logic                            obuf_arst,

  input  logic [C_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
  input  logic [C_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic                            s_axis_tvalid,
  output logic                            s_axis_tready,
  input  logic                            s_axis_tlast,

  output logic [C_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [C_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
  output logic [C_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic                            m_axis_tlast,

  output logic [31:0]                     stat_pkt_fwd,
  output logic [31:0]                     stat_pkt_drop,
  output logic [DATA_DEPTH_LOG2:0]        stat_fill
);

  localparam int KEEP_W  = C_AXIS_DATA_WIDTH / 8;
  localparam int PTR_W   = DATA_DEPTH_LOG2 + 1;
  localparam int MPTR_W  = META_DEPTH_LOG2 + 1;
  localparam int ENTRY_W = C_AXIS_DATA_WIDTH + KEEP_W + 1;

  localparam logic [PTR_W-1:0]  DATA_DEPTH = PTR_W'(1 << DATA_DEPTH_LOG2);
  localparam logic [MPTR_W-1:0] META_DEPTH = MPTR_W'(1 << META_DEPTH_LOG2);

  typedef enum logic [1:0] {W_IDLE, W_PKT, W_DROP} w_state_t;
  typedef enum logic       {R_IDLE, R_PKT}         r_state_t;

  // Storage
  logic [ENTRY_W-1:0]            data_mem [0:(1<<DATA_DEPTH_LOG2)-1];
  logic [C_AXIS_TUSER_WIDTH-1:0] meta_mem [0:(1<<META_DEPTH_LOG2)-1];

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [PTR_W-1:0]  wr_ptr, commit_ptr, rd_ptr, fill;
  logic [MPTR_W-1:0] meta_wr_ptr, meta_rd_ptr, pkt_cnt;

  w_state_t w_state, w_next;
  r_state_t r_state, r_next;

  logic                          ready_q;
  logic [C_AXIS_TUSER_WIDTH-1:0] pend_tuser;
  logic [C_AXIS_TUSER_WIDTH-1:0] meta_push_data;

  logic beat_in, data_full, meta_full, meta_empty;
  logic wr_en, commit, rollback, drop_pkt, latch_tuser;
  logic rd_accept, pkt_done, meta_pop;

  assign s_axis_tready = ready_q;
  assign beat_in       = s_axis_tvalid & ready_q;

  assign fill      = wr_ptr - rd_ptr;
  assign stat_fill = fill;
  assign data_full = (fill == DATA_DEPTH);

  // pkt_cnt counts committed packets that have not finished leaving, including
  // the one whose tuser already sits in m_axis_tuser. Limiting it to the meta
  // depth caps the number of live packets and means a commit can never
  // overflow the meta FIFO, because fullness is only tested at packet start.
  assign meta_full  = (pkt_cnt == META_DEPTH);
  assign meta_empty = (meta_wr_ptr == meta_rd_ptr);

  // A single-beat packet commits in the same cycle its tuser is sampled, so
  // pend_tuser is bypassed in that case.
  assign meta_push_data = (w_state == W_IDLE) ? s_axis_tuser : pend_tuser;

  // ---------------------------------------------------------------------------
  // Write FSM: next state and control
  // ---------------------------------------------------------------------------
  // NOTE: every always_comb output gets a default first so no path can leave
  // a value unassigned and infer a latch.
  always_comb begin
    w_next      = w_state;
    wr_en       = 1'b0;
    commit      = 1'b0;
    rollback    = 1'b0;
    drop_pkt    = 1'b0;
    latch_tuser = 1'b0;
    if (beat_in) begin
      case (w_state)
        W_IDLE: begin
          if (meta_full || data_full) begin
            if (s_axis_tlast) drop_pkt = 1'b1;
            else              w_next   = W_DROP;
          end else begin
            wr_en       = 1'b1;
            latch_tuser = 1'b1;
            if (s_axis_tlast) commit = 1'b1;
            else              w_next = W_PKT;
          end
        end
        W_PKT: begin
          if (data_full) begin
            // Discard the partial packet by rewinding to the last commit.
            rollback = 1'b1;
            if (s_axis_tlast) begin
              drop_pkt = 1'b1;
              w_next   = W_IDLE;
            end else begin
              w_next   = W_DROP;
            end
          end else begin
            wr_en = 1'b1;
            if (s_axis_tlast) begin
              commit = 1'b1;
              w_next = W_IDLE;
            end
          end
        end
        W_DROP: begin
          if (s_axis_tlast) begin
            drop_pkt = 1'b1;
            w_next   = W_IDLE;
          end
        end
        default: w_next = W_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Read FSM: next state and output datapath
  // ---------------------------------------------------------------------------
  always_comb begin
    m_axis_tvalid = (r_state == R_PKT);
    {m_axis_tdata, m_axis_tkeep, m_axis_tlast} =
      data_mem[rd_ptr[DATA_DEPTH_LOG2-1:0]];
    rd_accept = m_axis_tvalid & m_axis_tready;
    pkt_done  = rd_accept & m_axis_tlast;
    meta_pop  = 1'b0;
    r_next    = r_state;
    case (r_state)
      R_IDLE: begin
        if (!meta_empty) begin
          meta_pop = 1'b1;
          r_next   = R_PKT;
        end
      end
      R_PKT: begin
        // Chain directly into the next packet so there is no idle beat.
        if (pkt_done) begin
          if (!meta_empty) meta_pop = 1'b1;
          else             r_next   = R_IDLE;
        end
      end
      default: r_next = R_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Storage arrays
  // ---------------------------------------------------------------------------
  // NOTE: the RAM arrays have no reset; the pointers alone decide what is
  // valid, which keeps them mappable to LUTRAM.
  always_ff @(posedge obuf_aclk) begin
    if (wr_en)  data_mem[wr_ptr[DATA_DEPTH_LOG2-1:0]] <= {s_axis_tdata, s_axis_tkeep, s_axis_tlast};
    if (commit) meta_mem[meta_wr_ptr[META_DEPTH_LOG2-1:0]] <= meta_push_data;
  end

  // ---------------------------------------------------------------------------
  // State, pointers and counters
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge obuf_aclk or posedge obuf_arst) begin
    if (obuf_arst) begin
      ready_q       <= 1'b0;
      w_state       <= W_IDLE;
      r_state       <= R_IDLE;
      wr_ptr        <= '0;
      commit_ptr    <= '0;
      rd_ptr        <= '0;
      meta_wr_ptr   <= '0;
      meta_rd_ptr   <= '0;
      pkt_cnt       <= '0;
      pend_tuser    <= '0;
      m_axis_tuser  <= '0;
      stat_pkt_fwd  <= '0;
      stat_pkt_drop <= '0;
    end else begin
      ready_q <= 1'b1;
      w_state <= w_next;
      r_state <= r_next;

      if (rollback)   wr_ptr <= commit_ptr;
      else if (wr_en) wr_ptr <= wr_ptr + 1'b1;

      if (commit) begin
        commit_ptr  <= wr_ptr + 1'b1;
        meta_wr_ptr <= meta_wr_ptr + 1'b1;
      end

      if (latch_tuser) pend_tuser <= s_axis_tuser;

      if (meta_pop) begin
        m_axis_tuser <= meta_mem[meta_rd_ptr[META_DEPTH_LOG2-1:0]];
        meta_rd_ptr  <= meta_rd_ptr + 1'b1;
      end

      if (rd_accept) rd_ptr <= rd_ptr + 1'b1;

      case ({commit, pkt_done})
        2'b10:   pkt_cnt <= pkt_cnt + 1'b1;
        2'b01:   pkt_cnt <= pkt_cnt - 1'b1;
        default: pkt_cnt <= pkt_cnt;
      endcase

      if (drop_pkt) stat_pkt_drop <= stat_pkt_drop + 32'd1;
      if (pkt_done) stat_pkt_fwd  <= stat_pkt_fwd + 32'd1;
    end
  end

endmodule

// File: tb/tb_axis_out_pkt_buffer.sv
// -----------------------------------------------------------------------------
// tb_axis_out_pkt_buffer
//
// Directed stimulus pushes the expected output beats into a scoreboard queue.
// A monitor on the falling edge pops and compares every accepted beat. It also
// checks that the outputs hold steady while the sink stalls.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_axis_out_pkt_buffer;

  localparam int DW = 256;
  localparam int KW = DW / 8;
  localparam int UW = 128;
  localparam int DL = 6;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
    logic [UW-1:0] user;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] s_tdata;
  logic [KW-1:0] s_tkeep;
  logic [UW-1:0] s_tuser;
  logic          s_tvalid, s_tready, s_tlast;
  logic [DW-1:0] m_tdata;
  logic [KW-1:0] m_tkeep;
  logic [UW-1:0] m_tuser;
  logic          m_tvalid, m_tready, m_tlast;
  logic [31:0]   fwd, drop;
  logic [DL:0]   fill;

  always #5 clk = ~clk;

  axis_out_pkt_buffer dut (
    .obuf_aclk     (clk),
    .obuf_arst     (rst),
    .s_axis_tdata  (s_tdata),
    .s_axis_tkeep  (s_tkeep),
    .s_axis_tuser  (s_tuser),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .s_axis_tlast  (s_tlast),
    .m_axis_tdata  (m_tdata),
    .m_axis_tkeep  (m_tkeep),
    .m_axis_tuser  (m_tuser),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .m_axis_tlast  (m_tlast),
    .stat_pkt_fwd  (fwd),
    .stat_pkt_drop (drop),
    .stat_fill     (fill)
  );

  beat_t exp_q[$];
  int    n_cmp   = 0;
  int    n_err   = 0;
  int    acc_cnt = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Monitor / scoreboard
  // ---------------------------------------------------------------------------
  beat_t cur, held, e;
  logic  held_v = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      held_v = 1'b0;
    end else begin
      cur = {m_tdata, m_tkeep, m_tlast, m_tuser};
      if (held_v) begin
        check("stall_valid", m_tvalid, 1);
        if (m_tvalid) begin
          check("stall_data", cur.data, held.data);
          check("stall_ctl", {cur.keep, cur.last, cur.user}, {held.keep, held.last, held.user});
        end
      end
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_beat: got data 0x%0h with no beat expected (t=%0t)", m_tdata, $time);
        end else begin
          e = exp_q.pop_front();
          check("beat_data", cur.data, e.data);
          check("beat_keep", cur.keep, e.keep);
          check("beat_last", cur.last, e.last);
          check("beat_user", cur.user, e.user);
        end
        acc_cnt++;
      end
      held_v = m_tvalid && !m_tready;
      held   = cur;
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (entered and left at posedge + 1)
  // ---------------------------------------------------------------------------
  task automatic send_pkt(input int nbeats, input logic [UW-1:0] user, input logic [15:0] tag,
                          input logic [KW-1:0] last_keep, input bit expect_out);
    for (int i = 0; i < nbeats; i++) begin
      beat_t b;
      b.data = {tag, 16'(i), 224'(i * 37 + 1)};
      b.keep = (i == nbeats - 1) ? last_keep : {KW{1'b1}};
      b.last = (i == nbeats - 1);
      b.user = user;
      s_tdata  = b.data;
      s_tkeep  = b.keep;
      s_tlast  = b.last;
      s_tuser  = (i == 0) ? user : {4{32'hDEAD_0000 + 32'(i)}};
      s_tvalid = 1'b1;
      if (expect_out) exp_q.push_back(b);
      @(posedge clk); #1;
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int cyc = 0;
    while (exp_q.size() != 0 && cyc < budget) begin
      @(posedge clk);
      cyc++;
    end
    #1;
    check({name, "_drain_left"}, exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Directed tests
  // ---------------------------------------------------------------------------
  initial begin
    int base, vcnt, c;
    rst      = 1'b1;
    s_tdata  = '0;
    s_tkeep  = '0;
    s_tuser  = '0;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    m_tready = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_m_tvalid", m_tvalid, 0);
    check("rst_s_tready", s_tready, 0);
    check("rst_fill", fill, 0);
    check("rst_fwd", fwd, 0);
    check("rst_drop", drop, 0);
    check("rst_m_tuser", m_tuser, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rel_s_tready_pre", s_tready, 0);
    @(posedge clk); #1;
    check("rel_s_tready", s_tready, 1);

    // 1) single-beat packet, two-cycle latency
    m_tready = 1'b1;
    send_pkt(1, 128'hA5, 16'h0001, 32'hFFFF_FFFF, 1);
    check("t1_lat_edgeN", m_tvalid, 0);
    @(posedge clk); #1;
    check("t1_lat_edgeN1", m_tvalid, 1);
    check("t1_tuser", m_tuser, 128'hA5);
    check("t1_tlast", m_tlast, 1);
    wait_drain("t1", 20);
    check("t1_fwd", fwd, 1);

    // 2) four beats, tuser from beat 0 only
    send_pkt(4, 128'h11, 16'h0002, 32'h0000_00FF, 1);
    wait_drain("t2", 30);
    check("t2_fwd", fwd, 2);

    // 3) ten packets while stalled: eight stored, two dropped
    m_tready = 1'b0;
    for (int p = 0; p < 10; p++)
      send_pkt(4, 128'h100 + 128'(p), 16'h0030 + 16'(p), 32'h0F0F_0F0F, p < 8);
    check("t3_fill", fill, 32);
    check("t3_drop", drop, 2);
    check("t3_tvalid", m_tvalid, 1);
    check("t3_tuser_head", m_tuser, 128'h100);
    m_tready = 1'b1;
    vcnt = 0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      if (m_tvalid) vcnt++;
    end
    check("t3_no_bubble", vcnt, 32);
    wait_drain("t3", 20);
    check("t3_fwd", fwd, 10);
    check("t3_fill_empty", fill, 0);

    // 4) 70-beat packet overflows and rolls back; the next packet survives
    m_tready = 1'b0;
    send_pkt(70, 128'h70, 16'h0070, 32'hFFFF_FFFF, 0);
    check("t4_drop", drop, 3);
    check("t4_fill", fill, 0);
    check("t4_no_valid", m_tvalid, 0);
    send_pkt(2, 128'h22, 16'h0022, 32'h000F_FFFF, 1);
    check("t4_fill2", fill, 2);
    m_tready = 1'b1;
    wait_drain("t4", 20);
    check("t4_fwd", fwd, 11);

    // 5) random ready toggling on a 3-beat packet
    base = acc_cnt;
    m_tready = 1'b0;
    send_pkt(3, 128'h33, 16'h0033, 32'h0000_0003, 1);
    c = 0;
    while (exp_q.size() != 0 && c < 200) begin
      m_tready = (c < 2) ? 1'b0 : 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      c++;
    end
    m_tready = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("t5_accepted", acc_cnt - base, 3);
    check("t5_idle", m_tvalid, 0);
    check("t5_fwd", fwd, 12);

    // 6) reset in the middle of an outbound packet
    m_tready = 1'b1;
    base = acc_cnt;
    send_pkt(5, 128'h55, 16'h0055, 32'hFFFF_FFFF, 1);
    c = 0;
    while (acc_cnt - base < 2 && c < 50) begin
      @(negedge clk);
      c++;
    end
    check("t6_mid_pkt", m_tvalid, 1);
    #2;
    rst = 1'b1;
    #1;
    exp_q.delete();
    check("t6_tvalid", m_tvalid, 0);
    check("t6_fill", fill, 0);
    check("t6_fwd", fwd, 0);
    check("t6_drop", drop, 0);
    check("t6_s_tready", s_tready, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("t6_s_tready_rel", s_tready, 1);
    send_pkt(1, 128'h66, 16'h0066, 32'hFFFF_FFFF, 1);
    wait_drain("t6", 20);
    check("t6_fwd_after", fwd, 1);
    check("t6_drop_after", drop, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
